calltrace_reader: RTL

- Bus-master dump engine on the calltrace unit's two-register control/data port.
- On a start pulse it performs these steps against the calltrace stack of the current process (selected by cp_pid at the calltrace unit):
  - freezes that stack;
  - reads its status;
  - reads back every stacked LNK entry, top first;
  - streams the entries out on a valid/ready interface;
  - unfreezes the stack.
- Used by the error/trap monitor to capture a stack trace without losing stacked data.

---
 rtl/calltrace_pkg.sv | 29 ++
 rtl/ct_bus_master.sv | 62 ++++++
 rtl/calltrace_reader.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/calltrace_pkg.sv
// Calltrace port control words, status field positions and dump FSM states.
// Shared by the dump engine and its bus master; no logic, no latency.
package calltrace_pkg;

  localparam logic [23:0] CT_CLEAR    = 24'h000002;
  localparam logic [23:0] CT_FREEZE   = 24'h000004;
  localparam logic [23:0] CT_UNFREEZE = 24'h000008;
  localparam logic [23:0] CT_BLOCK    = 24'h000010;
  localparam logic [23:0] CT_UNBLOCK  = 24'h000020;

  localparam int ST_OVFL_BIT   = 2;
  localparam int ST_FROZEN_BIT = 3;
  localparam int ST_COUNT_LSB  = 8;
  localparam int ST_MAXCNT_LSB = 16;
  localparam int ST_PID_LSB    = 24;

  typedef enum logic [3:0] {
    S_IDLE,
    S_BLOCK,
    S_FREEZE,
    S_STATUS,
    S_READ,
    S_EMIT,
    S_UNFREEZE,
    S_UNBLOCK,
    S_DONE
  } state_t;

endpackage

// File: rtl/ct_bus_master.sv
// Single calltrace access: strobe held until ack or TIMEOUT cycles; ack/timeout pulse one cycle later.
// New access launches only when req is high and no completion pulse is pending, forcing a strobe gap.
module ct_bus_master #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic        addr,
  input  logic [23:0] wdata,
  output logic        ack,
  output logic        timeout,
  output logic [31:0] rdata,
  output logic        ct_stb,
  output logic        ct_we,
  output logic        ct_addr,
  output logic [23:0] ct_wdata,
  input  logic [31:0] ct_rdata,
  input  logic        ct_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_stb   <= 1'b0;
      ct_we    <= 1'b0;
      ct_addr  <= 1'b0;
      ct_wdata <= '0;
      ack      <= 1'b0;
      timeout  <= 1'b0;
      rdata    <= '0;
      wait_cnt <= '0;
    end else begin
      ack     <= 1'b0;
      timeout <= 1'b0;
      if (ct_stb) begin
        if (ct_ack) begin
          ct_stb <= 1'b0;
          ack    <= 1'b1;
          rdata  <= ct_rdata;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          ct_stb  <= 1'b0;
          timeout <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end else if (req && !ack && !timeout) begin
        // command is latched here so it stays stable for the whole strobe
        ct_stb   <= 1'b1;
        ct_we    <= we;
        ct_addr  <= addr;
        ct_wdata <= wdata;
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/calltrace_reader.sv
// Freezes the current calltrace stack, streams its entries top-first on valid/ready, then unfreezes.
// EMIT stalls indefinitely on out_ready; CALLTRACE_READER_BLOCK_EN wraps the dump in block/unblock writes.
module calltrace_reader
  import calltrace_pkg::*;
#(
  parameter int MAX_ENTRIES = 32,
  parameter int DATA_W      = 24,
  parameter int TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ct_stb,
  output logic              ct_we,
  output logic              ct_addr,
  output logic [23:0]       ct_wdata,
  input  logic [31:0]       ct_rdata,
  input  logic              ct_ack,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [4:0]        pid,
  output logic              ovfl,
  output logic [7:0]        count
);

  localparam int RW = $clog2(MAX_ENTRIES + 1);

`ifdef CALLTRACE_READER_BLOCK_EN
  localparam state_t FIRST_ST = S_BLOCK;
  localparam state_t ABORT_ST = S_UNBLOCK;
  localparam state_t TAIL_ST  = S_UNBLOCK;
`else
  localparam state_t FIRST_ST = S_FREEZE;
  localparam state_t ABORT_ST = S_DONE;
  localparam state_t TAIL_ST  = S_DONE;
`endif

  state_t        state, next;
  logic          req, we, addr;
  logic [23:0]   wdata;
  logic          bm_ack, bm_to;
  logic [31:0]   bm_rdata;
  logic [7:0]    st_count;
  logic [RW-1:0] remaining;
  logic          unused_bits;

  assign st_count    = bm_rdata[ST_COUNT_LSB +: 8];
  assign unused_bits = ^bm_rdata[31:29];

  ct_bus_master #(.TIMEOUT(TIMEOUT)) u_bus (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .ack      (bm_ack),
    .timeout  (bm_to),
    .rdata    (bm_rdata),
    .ct_stb   (ct_stb),
    .ct_we    (ct_we),
    .ct_addr  (ct_addr),
    .ct_wdata (ct_wdata),
    .ct_rdata (ct_rdata),
    .ct_ack   (ct_ack)
  );

  always_comb begin
    next  = state;
    req   = 1'b0;
    we    = 1'b0;
    addr  = 1'b0;
    wdata = '0;
    unique case (state)
      S_IDLE: if (start) next = FIRST_ST;
      S_BLOCK: begin
        {req, we, addr, wdata} = {1'b1, 1'b1, 1'b1, CT_BLOCK};
        if (bm_to)       next = S_DONE;
        else if (bm_ack) next = S_FREEZE;
      end
      S_FREEZE: begin
        {req, we, addr, wdata} = {1'b1, 1'b1, 1'b1, CT_FREEZE};
        if (bm_to)       next = ABORT_ST;
        else if (bm_ack) next = S_STATUS;
      end
      S_STATUS: begin
        {req, addr} = 2'b11;
        if (bm_to)       next = ABORT_ST;
        else if (bm_ack) next = (st_count == 8'd0) ? S_UNFREEZE : S_READ;
      end
      S_READ: begin
        req = 1'b1;
        if (bm_to)       next = ABORT_ST;
        else if (bm_ack) next = S_EMIT;
      end
      S_EMIT: if (out_ready) next = (remaining == RW'(1)) ? S_UNFREEZE : S_READ;
      S_UNFREEZE: begin
        {req, we, addr, wdata} = {1'b1, 1'b1, 1'b1, CT_UNFREEZE};
        if (bm_to)       next = ABORT_ST;
        else if (bm_ack) next = TAIL_ST;
      end
      S_UNBLOCK: begin
        // attempted exactly once, even after an earlier timeout
        {req, we, addr, wdata} = {1'b1, 1'b1, 1'b1, CT_UNBLOCK};
        if (bm_to || bm_ack) next = S_DONE;
      end
      S_DONE:  next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      err       <= 1'b0;
      pid       <= '0;
      ovfl      <= 1'b0;
      count     <= '0;
      remaining <= '0;
      out_data  <= '0;
    end else begin
      state <= next;
      if (state == S_IDLE && start) err <= 1'b0;
      if (bm_to) err <= 1'b1;
      if (state == S_STATUS && bm_ack) begin
        pid       <= bm_rdata[ST_PID_LSB +: 5];
        ovfl      <= bm_rdata[ST_OVFL_BIT];
        count     <= st_count;
        remaining <= (st_count > 8'(MAX_ENTRIES)) ? RW'(MAX_ENTRIES) : RW'(st_count);
      end
      if (state == S_READ && bm_ack) out_data <= bm_rdata[DATA_W-1:0];
      if (state == S_EMIT && out_ready) remaining <= remaining - 1'b1;
    end
  end

  assign out_valid = (state == S_EMIT);
  assign out_last  = (state == S_EMIT) && (remaining == RW'(1));
  assign done      = (state == S_DONE);
  assign busy      = (state != S_IDLE) && (state != S_DONE);

endmodule
